// File: rtl/alu_ctl_pkg.sv
// Shared types for the ALU sequencer: operation codes, flag word and FSM state.
package alu_ctl_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_ADC = 3'd5,
      OP_NOP = 3'd7
   } alu_operation_e;

   typedef struct packed {
      logic s;
      logic z;
      logic ac;
      logic cy;
   } flags_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } alu_ctl_state_e;

   localparam int OPND_W   = 16;
   localparam int RESULT_W = 32;

endpackage

// File: rtl/alu_ctl_if.sv
// Requester and ALU-side bus of the shared ALU sequencer.
interface alu_ctl_if #(
   parameter int NREQ = 2
) ();
   import alu_ctl_pkg::*;

   logic [NREQ-1:0]     req;
   alu_operation_e      req_op    [NREQ];
   logic [OPND_W-1:0]   req_ta    [NREQ];
   logic [OPND_W-1:0]   req_tb    [NREQ];
   logic [NREQ-1:0]     req_wide;
   flags_t              req_flags [NREQ];
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic [RESULT_W-1:0] rsp_result;
   flags_t              rsp_flags;
   logic                rsp_err;
   alu_operation_e      alu_operation;
   logic [OPND_W-1:0]   alu_ta;
   logic [OPND_W-1:0]   alu_tb;
   logic                alu_wide;
   flags_t              alu_flags_in;
   logic                alu_execute;
   logic                alu_busy;
   logic [RESULT_W-1:0] alu_result;
   flags_t              alu_flags;
   logic                active;

   modport master (
      output req, req_op, req_ta, req_tb, req_wide, req_flags,
      output alu_busy, alu_result, alu_flags,
      input  gnt, done, rsp_result, rsp_flags, rsp_err,
      input  alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in, alu_execute, active
   );

   modport slave (
      input  req, req_op, req_ta, req_tb, req_wide, req_flags,
      input  alu_busy, alu_result, alu_flags,
      output gnt, done, rsp_result, rsp_flags, rsp_err,
      output alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in, alu_execute, active
   );

endinterface

// File: rtl/alu_ctl_rr_arbiter.sv
// Round-robin requester selection; one-hot grant, search starts after last_grant.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [NREQ-1:0]         grant
);
   localparam int IDX_W = $clog2(NREQ);

   logic [IDX_W-1:0] idx;
   logic             found;

   // First active requester walking upward from last_grant+1, wrapping at NREQ.
   always_comb begin
      grant = {NREQ{1'b0}};
      found = 1'b0;
      idx   = {IDX_W{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDX_W'((int'(last_grant) + k) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/alu_ctl.sv
// Shares one ALU between NREQ requesters: arbitrate, issue, wait with watchdog, respond.
module alu_ctl
   import alu_ctl_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int WAIT_MAX = 15
) (
   input  logic      clk,
   input  logic      reset_n,
   input  logic      ce,
   alu_ctl_if.slave  bus
);
   localparam int IDX_W = $clog2(NREQ);
   localparam int WD_W  = $clog2(WAIT_MAX + 1);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ISSUE = ST_ISSUE;
   localparam logic [1:0] S_WAIT  = ST_WAIT;
   localparam logic [1:0] S_RESP  = ST_RESP;

   logic [1:0]          state;
   logic [IDX_W-1:0]    last_grant;
   logic [IDX_W-1:0]    cur;
   logic [IDX_W-1:0]    win;
   logic [NREQ-1:0]     grant;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic                alu_execute;
   logic                active;
   logic [WD_W-1:0]     wdog;
   logic [RESULT_W-1:0] rsp_result;
   flags_t              rsp_flags;
   logic                rsp_err;
   alu_operation_e      op;
   logic [OPND_W-1:0]   ta;
   logic [OPND_W-1:0]   tb;
   logic                wide;
   flags_t              flags_in;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req        (bus.req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // One-hot arbiter result to an index for the operand mux.
   always_comb begin
      win = {IDX_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         win = win | (grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
      end
   end

   // Sequencer: grant and operand latch, execute pulse, watchdog, response capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         last_grant  <= IDX_W'(NREQ - 1);
         cur         <= {IDX_W{1'b0}};
         gnt         <= {NREQ{1'b0}};
         done        <= {NREQ{1'b0}};
         alu_execute <= 1'b0;
         active      <= 1'b0;
         wdog        <= {WD_W{1'b0}};
         rsp_result  <= {RESULT_W{1'b0}};
         rsp_flags   <= flags_t'(4'b0000);
         rsp_err     <= 1'b0;
         op          <= OP_ADD;
         ta          <= {OPND_W{1'b0}};
         tb          <= {OPND_W{1'b0}};
         wide        <= 1'b0;
         flags_in    <= flags_t'(4'b0000);
      end else if (ce) begin
         case (state)
            S_IDLE: begin
               done <= {NREQ{1'b0}};
               if (|bus.req) begin
                  state       <= S_ISSUE;
                  active      <= 1'b1;
                  gnt         <= grant;
                  last_grant  <= win;
                  cur         <= win;
                  alu_execute <= 1'b1;
                  op          <= bus.req_op[win];
                  ta          <= bus.req_ta[win];
                  tb          <= bus.req_tb[win];
                  wide        <= bus.req_wide[win];
                  flags_in    <= bus.req_flags[win];
               end else begin
                  gnt <= {NREQ{1'b0}};
               end
            end
            S_ISSUE: begin
               gnt         <= {NREQ{1'b0}};
               alu_execute <= 1'b0;
               wdog        <= {WD_W{1'b0}};
               state       <= S_WAIT;
            end
            S_WAIT: begin
               if (!bus.alu_busy) begin
                  rsp_result <= bus.alu_result;
                  rsp_flags  <= bus.alu_flags;
                  rsp_err    <= 1'b0;
                  done       <= {{(NREQ-1){1'b0}}, 1'b1} << cur;
                  state      <= S_RESP;
               end else if (wdog == WD_W'(WAIT_MAX - 1)) begin
                  // Abort: result zeroed, flags fall back to what the requester supplied.
                  rsp_result <= {RESULT_W{1'b0}};
                  rsp_flags  <= flags_in;
                  rsp_err    <= 1'b1;
                  done       <= {{(NREQ-1){1'b0}}, 1'b1} << cur;
                  state      <= S_RESP;
               end else begin
                  wdog <= wdog + WD_W'(1);
               end
            end
            S_RESP: begin
               done   <= {NREQ{1'b0}};
               active <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state       <= S_IDLE;
               gnt         <= {NREQ{1'b0}};
               done        <= {NREQ{1'b0}};
               alu_execute <= 1'b0;
               active      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt           = gnt;
   assign bus.done          = done;
   assign bus.rsp_result    = rsp_result;
   assign bus.rsp_flags     = rsp_flags;
   assign bus.rsp_err       = rsp_err;
   assign bus.alu_operation = op;
   assign bus.alu_ta        = ta;
   assign bus.alu_tb        = tb;
   assign bus.alu_wide      = wide;
   assign bus.alu_flags_in  = flags_in;
   assign bus.alu_execute   = alu_execute;
   assign bus.active        = active;

endmodule

// File: tb/tb_alu_ctl.sv
// Bench for alu_ctl: vector table through a modelled ALU, plus arbitration, ce, watchdog and reset sequences.
module tb_alu_ctl;
   import alu_ctl_pkg::*;

   typedef struct {
      int             rq;
      alu_operation_e op;
      logic [15:0]    ta;
      logic [15:0]    tb;
      logic           wide;
      logic [3:0]     fin;
      logic [31:0]    res;
      logic [3:0]     fout;
   } vec_t;

   typedef struct {
      logic [1:0]  done;
      logic [31:0] res;
      logic [3:0]  flags;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce;
   logic        stuck_busy;
   logic [35:0] alu_out = 36'd0;
   int          checks = 0;
   int          failures = 0;
   int          done_seen = 0;
   exp_t        sbq[$];
   vec_t        vecs[8];

   alu_ctl_if #(.NREQ(2)) bus ();

   alu_ctl #(.NREQ(2), .WAIT_MAX(15)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {s,z,ac,cy, 16'b0, result16}.
   function automatic logic [35:0] alu_ref(input alu_operation_e op, input logic [15:0] ta,
                                           input logic [15:0] tb, input logic wide, input logic cin);
      logic [16:0] a, b, r;
      logic [15:0] m, r16;
      logic        cy, ac, z, s, c;
      m  = wide ? 16'hFFFF : 16'h00FF;
      a  = {1'b0, ta & m};
      b  = {1'b0, tb & m};
      cy = 1'b0;
      ac = 1'b0;
      c  = (op == OP_ADC) ? cin : 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            r  = a + b + {16'd0, c};
            ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c}) > 5'h0F;
            cy = wide ? r[16] : r[8];
         end
         OP_SUB: begin
            r  = a - b;
            cy = a < b;
            ac = a[3:0] < b[3:0];
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = 17'd0;
      endcase
      r16 = r[15:0] & m;
      z   = (r16 == 16'd0);
      s   = wide ? r16[15] : r16[7];
      return {s, z, ac, cy, 16'd0, r16};
   endfunction

   // ALU model: result registered on each edge that sees execute.
   always @(posedge clk) begin
      if (bus.alu_execute) begin
         alu_out <= alu_ref(bus.alu_operation, bus.alu_ta, bus.alu_tb, bus.alu_wide, bus.alu_flags_in.cy);
      end
   end

   assign bus.alu_busy   = stuck_busy;
   assign bus.alu_result = {16'd0, alu_out[15:0]};
   assign bus.alu_flags  = flags_t'(alu_out[35:32]);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Scoreboard: each rising done pops one expected response.
   initial begin : monitor
      logic [1:0] done_q;
      exp_t       e;
      done_q = 2'b00;
      forever begin
         @(negedge clk);
         if (reset_n && (bus.done != 2'b00) && (done_q == 2'b00)) begin
            done_seen++;
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("done_onehot", 32'(bus.done), 32'(e.done));
               chk("rsp_result", bus.rsp_result, e.res);
               chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
         end
         done_q = bus.done;
      end
   end

   task automatic drive(input int rq, input alu_operation_e op, input logic [15:0] ta,
                        input logic [15:0] tb, input logic wide, input logic [3:0] fin);
      bus.req[rq]       = 1'b1;
      bus.req_op[rq]    = op;
      bus.req_ta[rq]    = ta;
      bus.req_tb[rq]    = tb;
      bus.req_wide[rq]  = wide;
      bus.req_flags[rq] = flags_t'(fin);
   endtask

   task automatic push_exp(input int rq, input logic [31:0] res, input logic [3:0] fl, input logic err);
      exp_t e;
      e.done  = (rq == 0) ? 2'b01 : 2'b10;
      e.res   = res;
      e.flags = fl;
      e.err   = err;
      sbq.push_back(e);
   endtask

   task automatic wait_gnt(input int rq, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.gnt[rq]) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) chk("gnt_timeout", 32'(bus.gnt[rq]), 32'd1);
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.done != 2'b00) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) chk("done_timeout", 32'(bus.done != 2'b00), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int c;
      drive(v.rq, v.op, v.ta, v.tb, v.wide, v.fin);
      push_exp(v.rq, v.res, v.fout, 1'b0);
      wait_gnt(v.rq, c);
      chk("gnt_latency", c, 32'd1);
      chk("gnt_onehot", 32'(bus.gnt), (v.rq == 0) ? 32'd1 : 32'd2);
      chk("exec_in_issue", 32'(bus.alu_execute), 32'd1);
      chk("alu_ta_latched", 32'(bus.alu_ta), 32'(v.ta));
      bus.req[v.rq]    = 1'b0;
      bus.req_ta[v.rq] = 16'hDEAD;
      bus.req_tb[v.rq] = 16'hBEEF;
      wait_done(c);
      chk("gnt_to_done", c, 32'd2);
      chk("alu_tb_held", 32'(bus.alu_tb), 32'(v.tb));
      chk("alu_op_held", 32'(bus.alu_operation), 32'(v.op));
      @(negedge clk);
      chk("idle_after_resp", 32'(bus.active), 32'd0);
   endtask

   initial begin : global_timeout
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin : stim
      int c, ng, g1, snap;
      int gidx[4], gcyc[4];
      int gc, gce, ec, ece, dc, dce;

      vecs[0] = '{0, OP_ADD, 16'h00FF, 16'h0001, 1'b1, 4'b0000, 32'h0000_0100, 4'b0010};
      vecs[1] = '{1, OP_ADD, 16'h00FF, 16'h0001, 1'b0, 4'b0000, 32'h0000_0000, 4'b0111};
      vecs[2] = '{0, OP_SUB, 16'h1000, 16'h0001, 1'b1, 4'b0000, 32'h0000_0FFF, 4'b0010};
      vecs[3] = '{1, OP_AND, 16'hF0F0, 16'hFF00, 1'b1, 4'b0000, 32'h0000_F000, 4'b1000};
      vecs[4] = '{0, OP_XOR, 16'hAAAA, 16'hAAAA, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100};
      vecs[5] = '{1, OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 4'b0001, 32'h0000_0000, 4'b0111};
      vecs[6] = '{0, OP_SUB, 16'h0012, 16'h0034, 1'b0, 4'b0000, 32'h0000_00DE, 4'b1011};
      vecs[7] = '{1, OP_OR,  16'h1201, 16'h3410, 1'b0, 4'b0000, 32'h0000_0011, 4'b0000};

      reset_n    = 1'b0;
      ce         = 1'b1;
      stuck_busy = 1'b0;
      bus.req    = 2'b00;
      bus.req_wide = 2'b00;
      for (int i = 0; i < 2; i++) begin
         bus.req_op[i]    = OP_ADD;
         bus.req_ta[i]    = 16'h0000;
         bus.req_tb[i]    = 16'h0000;
         bus.req_flags[i] = flags_t'(4'b0000);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_exec", 32'(bus.alu_execute), 32'd0);
      chk("rst_active", 32'(bus.active), 32'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_alu_ta", 32'(bus.alu_ta), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Both requesters held: grants alternate 0,1,0,1 four cycles apart.
      drive(0, OP_ADD, 16'h1111, 16'h2222, 1'b1, 4'b0000);
      drive(1, OP_ADD, 16'h0080, 16'h0080, 1'b0, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) push_exp(0, 32'h0000_3333, 4'b0000, 1'b0);
         else            push_exp(1, 32'h0000_0000, 4'b0101, 1'b0);
         gidx[k] = -1;
         gcyc[k] = -100;
      end
      ng = 0;
      for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
         @(negedge clk);
         if (bus.gnt != 2'b00) begin
            gidx[ng] = bus.gnt[1] ? 1 : 0;
            gcyc[ng] = cyc;
            ng++;
         end
      end
      bus.req = 2'b00;
      chk("rr_grant_count", ng, 32'd4);
      for (int k = 0; k < 4; k++) chk("rr_order", gidx[k], 32'(k % 2));
      for (int k = 1; k < 4; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 32'd4);
      repeat (6) @(negedge clk);

      // ce toggling: every pulse spans exactly one ce=1 edge, result unchanged.
      drive(0, OP_ADD, 16'h00FF, 16'h0001, 1'b1, 4'b0000);
      push_exp(0, 32'h0000_0100, 4'b0010, 1'b0);
      gc = 0; gce = 0; ec = 0; ece = 0; dc = 0; dce = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         ce = ~ce;
         if (bus.gnt[0]) begin
            gc++;
            if (ce) gce++;
            bus.req[0] = 1'b0;
         end
         if (bus.alu_execute) begin
            ec++;
            if (ce) ece++;
         end
         if (bus.done[0]) begin
            dc++;
            if (ce) dce++;
         end
      end
      ce = 1'b1;
      chk("ce_gnt_edges", gce, 32'd1);
      chk("ce_exec_edges", ece, 32'd1);
      chk("ce_done_edges", dce, 32'd1);
      chk("ce_gnt_held", gc, 32'd2);
      chk("ce_exec_held", ec, 32'd2);
      chk("ce_done_held", dc, 32'd2);
      @(negedge clk);

      // Watchdog: busy stuck high aborts after 15 WAIT cycles.
      stuck_busy = 1'b1;
      drive(0, OP_ADD, 16'h0001, 16'h0001, 1'b1, 4'b1010);
      push_exp(0, 32'h0000_0000, 4'b1010, 1'b1);
      wait_gnt(0, c);
      bus.req[0] = 1'b0;
      wait_done(c);
      chk("wdog_gnt_to_done", c, 32'd16);
      stuck_busy = 1'b0;
      @(negedge clk);
      run_vec(vecs[0]);

      // Reset in WAIT: no done, reset values, requester 0 wins next contention.
      stuck_busy = 1'b1;
      drive(1, OP_SUB, 16'h0005, 16'h0003, 1'b1, 4'b0000);
      wait_gnt(1, c);
      bus.req[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("active_in_wait", 32'(bus.active), 32'd1);
      snap = done_seen;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_active", 32'(bus.active), 32'd0);
      chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
      chk("mid_rst_exec", 32'(bus.alu_execute), 32'd0);
      chk("mid_rst_rsp_result", bus.rsp_result, 32'd0);
      chk("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("mid_rst_alu_ta", 32'(bus.alu_ta), 32'd0);
      @(negedge clk);
      reset_n    = 1'b1;
      stuck_busy = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_after_reset", done_seen, snap);
      drive(0, OP_ADD, 16'h0003, 16'h0004, 1'b1, 4'b0000);
      drive(1, OP_XOR, 16'h00F0, 16'h000F, 1'b0, 4'b0000);
      push_exp(0, 32'h0000_0007, 4'b0000, 1'b0);
      push_exp(1, 32'h0000_00FF, 4'b1000, 1'b0);
      wait_gnt(0, c);
      chk("post_rst_first_latency", c, 32'd1);
      chk("post_rst_first_gnt", 32'(bus.gnt), 32'd1);
      bus.req[0] = 1'b0;
      wait_gnt(1, c);
      chk("post_rst_second_spacing", c, 32'd4);
      bus.req[1] = 1'b0;
      repeat (5) @(negedge clk);

      // A request raised and dropped while busy is never granted.
      drive(0, OP_OR, 16'h0F00, 16'h00F0, 1'b1, 4'b0000);
      push_exp(0, 32'h0000_0FF0, 4'b0000, 1'b0);
      wait_gnt(0, c);
      bus.req[0] = 1'b0;
      g1 = 0;
      @(negedge clk);
      drive(1, OP_AND, 16'hFFFF, 16'hFFFF, 1'b1, 4'b0000);
      @(negedge clk);
      bus.req[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.gnt[1]) g1++;
      end
      chk("withdrawn_no_gnt", g1, 32'd0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
